zc_spi_host: RTL and testbench
==============================

Name: zc_spi_host

Overview:
- Byte-oriented SPI mode-0 master, Z-controller style, driving the SD card lines (SD_CLK/SD_MOSI/SD_MISO/SD_CS_N) from the CPU port side.
- Forms the initiator end of the link toward the virtual sd_card responder or the physical SD slot.
- CPU writes to the data port send a byte. CPU reads return the last received byte and launch a dummy 0xFF exchange.
- Sits inside the tsconf core on clk_sys, gated by the 28 MHz clock enable.

Parameters:
- DIV, 1, half-period of SD_CLK in ce ticks; legal range 1..255.
- ACT_TIMEOUT, 1000000, ce ticks that act stays high after the last transfer (optional feature only).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; the state machine advances only when ce=1
- tx_start  in  1  one-cycle strobe: send tx_data
- tx_data  in  8  byte to transmit
- rx_start  in  1  one-cycle strobe: send 0xFF (read-ahead)
- cs_wr  in  1  strobe: load the chip-select register
- cs_din  in  1  new SD_CS_N value
- busy  out  1  transfer in progress
- done  out  1  one-clk_sys pulse when a byte completes
- rx_data  out  8  last fully received byte
- SD_CLK  out  1  SPI clock, idles low
- SD_MOSI  out  1  SPI data out, MSB first
- SD_MISO  in  1  SPI data in
- SD_CS_N  out  1  chip select, active low, register-driven
- act  out  1  activity indicator (present only with ZC_SPI_ACT_EN)

Behaviour:
- Reset: apply asynchronously, as listed below.
  - SD_CS_N=1, SD_CLK=0, SD_MOSI=1.
  - busy=0, done=0, rx_data=8'hFF, act=0.
  - State=IDLE; all counters 0.
- States: IDLE, LOW, HIGH.
- IDLE:
  - tx_start=1 loads shreg<=tx_data, SD_MOSI<=tx_data[7], bit_cnt<=0, div_cnt<=DIV-1, busy<=1, state LOW.
  - rx_start=1 does the same with the byte 8'hFF.
  - Start strobes act regardless of ce.
  - If tx_start and rx_start are asserted together, tx_start wins.
- Strobes arriving while busy=1 are ignored. No queueing, no error flag.
- LOW state, on each ce tick:
  - If div_cnt≠0, decrement div_cnt.
  - Otherwise set SD_CLK<=1, shift SD_MISO into the rx shift register LSB, reload div_cnt<=DIV-1, state HIGH.
- HIGH state, on each ce tick:
  - If div_cnt≠0, decrement div_cnt.
  - Otherwise set SD_CLK<=0 and reload div_cnt.
  - If bit_cnt=7: rx_data<=assembled byte, busy<=0, done<=1 for exactly one clk_sys cycle, state IDLE.
  - Else: SD_MOSI<=next bit (MSB first), bit_cnt++, state LOW.
- Timing:
  - A transfer lasts exactly 16*DIV ce ticks from the strobe to busy falling.
  - SD_MISO is sampled on the rising SD_CLK edge. SD_MOSI changes on the falling edge, or at the start.
- After a transfer, SD_MOSI returns to 1 in IDLE.
- rx_data is stable and holds its value until the next completed byte. It never shows a partial byte.
- cs_wr:
  - SD_CS_N<=cs_din on the next clk_sys edge, independent of ce and busy.
  - A CS change mid-transfer does not abort the shift.
- The block does not gate SD_CLK with SD_CS_N.
- Reset mid-transfer: aborts immediately to the reset values; no done pulse.
- ce held at 0: all outputs freeze; busy is held.

Optional Feature:
- Macro ZC_SPI_ACT_EN.
- Defined:
  - Port act exists, plus a counter of clog2(ACT_TIMEOUT+1) bits.
  - Counter reloads to ACT_TIMEOUT on every transfer start and decrements per ce tick down to 0.
  - act=1 while counter≠0 or busy=1; feeds LED_DISK/LED_USER.
- Undefined: no act port and no counter; all other behaviour is identical.

Test Plan:
- All scenarios use DIV=1 and ce tied to 1 unless stated otherwise.
- Reset then idle 20 cycles:
  - SD_CS_N=1, SD_CLK=0, SD_MOSI=1, busy=0, rx_data=8'hFF.
- Write cs_din=0, then tx_start with tx_data=8'hA5 and SD_MISO driven by a slave model returning 8'h3C:
  - MOSI bits 1,0,1,0,0,1,0,1 on 8 rising edges.
  - busy high for 16 cycles.
  - done pulses once; rx_data=8'h3C.
- rx_start with the slave returning 8'h01:
  - MOSI is 1 for all bits; rx_data=8'h01.
- tx_start and rx_start in the same cycle with tx_data=8'h40:
  - MOSI carries 8'h40; a tx_start issued mid-transfer is ignored (one done only).
- DIV=3, ce asserted every 3rd cycle:
  - Transfer takes 48 ce ticks (144 clk_sys); SD_CLK high/low phases are 3 ce ticks each.
- Assert reset at bit 4 of a transfer:
  - Immediate reset values, rx_data=8'hFF, no done.
  - With ZC_SPI_ACT_EN and ACT_TIMEOUT=10: act=1 for exactly 10 ce ticks after a completed transfer ends.

Source files
------------

// File: rtl/zc_spi_host_if.sv
// -----------------------------------------------------------------------------
// zc_spi_host_if
// Purpose : groups the CPU-side handshake and the SD card SPI lines of the
//           Z-controller style SPI host into one bundle.
// Signals : tx_start/tx_data/rx_start  - transfer launch strobes and data
//           cs_wr/cs_din               - chip-select register write
//           busy/done/rx_data          - transfer status and received byte
//           SD_CLK/SD_MOSI/SD_MISO/SD_CS_N - SPI mode-0 card lines
// Modports: master - the SPI host itself (drives status and SD outputs)
//           slave  - everything around it (CPU port logic and the card)
// -----------------------------------------------------------------------------
interface zc_spi_host_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rx_start;
  logic       cs_wr;
  logic       cs_din;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       SD_CLK;
  logic       SD_MOSI;
  logic       SD_MISO;
  logic       SD_CS_N;

  modport master (
    input  tx_start, tx_data, rx_start, cs_wr, cs_din, SD_MISO,
    output busy, done, rx_data, SD_CLK, SD_MOSI, SD_CS_N
  );

  modport slave (
    output tx_start, tx_data, rx_start, cs_wr, cs_din, SD_MISO,
    input  busy, done, rx_data, SD_CLK, SD_MOSI, SD_CS_N
  );
endinterface

// File: rtl/zc_spi_host.sv
// -----------------------------------------------------------------------------
// zc_spi_host
// Purpose : byte-oriented SPI mode-0 master (Z-controller style) toward the SD
//           card. A CPU write sends a byte; a CPU read launches a dummy 0xFF
//           exchange and the last received byte is available on rx_data.
// Ports   : clk_sys - system clock
//           reset   - asynchronous active-high reset
//           ce      - clock enable; the shift engine only advances on ce=1
//           bus     - zc_spi_host_if.master (CPU strobes, status, SD lines)
//           act     - activity indicator, only with ZC_SPI_ACT_EN defined
// Params  : DIV         - SD_CLK half period in ce ticks (1..255)
//           ACT_TIMEOUT - ce ticks act stays high after the last transfer
//                         (only with ZC_SPI_ACT_EN defined)
// Options : `define ZC_SPI_ACT_EN adds the act port and its hold-off counter.
// -----------------------------------------------------------------------------
module zc_spi_host #(
  parameter int unsigned DIV = 1
`ifdef ZC_SPI_ACT_EN
  ,
  parameter int unsigned ACT_TIMEOUT = 1000000
`endif
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  zc_spi_host_if.master    bus
`ifdef ZC_SPI_ACT_EN
  ,
  output logic             act
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [7:0] DIV_RELOAD = 8'(DIV - 1);

  logic [1:0] state_q,   state_d;
  logic [7:0] div_q,     div_d;
  logic [2:0] bit_q,     bit_d;
  logic [7:0] tx_sh_q,   tx_sh_d;
  logic [7:0] rx_sh_q,   rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       sclk_q,    sclk_d;
  logic       mosi_q,    mosi_d;
  logic       cs_n_q,    cs_n_d;
  logic       start_s;

  // Strobes are only honoured in IDLE, so anything arriving while busy is dropped.
  assign start_s = (state_q == ST_IDLE) && (bus.tx_start || bus.rx_start);

  // Shift engine next-state logic.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          // tx_start wins over a simultaneous rx_start.
          tx_sh_d = bus.tx_start ? bus.tx_data : 8'hFF;
          mosi_d  = tx_sh_d[7];
          bit_d   = 3'd0;
          div_d   = DIV_RELOAD;
          busy_d  = 1'b1;
          state_d = ST_LOW;
        end else begin
          mosi_d  = 1'b1;
        end
      end
      ST_LOW: begin
        if (ce) begin
          if (div_q != 8'd0) begin
            div_d = div_q - 8'd1;
          end else begin
            // Rising SD_CLK edge: the card's bit is sampled here.
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], bus.SD_MISO};
            div_d   = DIV_RELOAD;
            state_d = ST_HIGH;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HIGH: begin
        if (ce) begin
          if (div_q != 8'd0) begin
            div_d = div_q - 8'd1;
          end else begin
            sclk_d = 1'b0;
            div_d  = DIV_RELOAD;
            if (bit_q == 3'd7) begin
              // Whole byte assembled: publish it in one step so rx_data never
              // shows a partial value.
              rx_data_d = rx_sh_q;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              mosi_d    = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              // Falling SD_CLK edge: present the next MSB-first bit.
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[6:0], 1'b1};
              bit_d   = bit_q + 3'd1;
              state_d = ST_LOW;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        mosi_d  = 1'b1;
      end
    endcase
  end

  // Chip select is a plain register, written regardless of ce and busy.
  always_comb begin
    if (bus.cs_wr) begin
      cs_n_d = bus.cs_din;
    end else begin
      cs_n_d = cs_n_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_sh_q   <= 8'd0;
      rx_sh_q   <= 8'd0;
      rx_data_q <= 8'hFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.SD_CLK  = sclk_q;
  assign bus.SD_MOSI = mosi_q;
  assign bus.SD_CS_N = cs_n_q;

`ifdef ZC_SPI_ACT_EN
  localparam int unsigned ACT_W = (ACT_TIMEOUT > 0) ? $clog2(ACT_TIMEOUT + 1) : 1;
  localparam logic [ACT_W-1:0] ACT_RELOAD = ACT_W'(ACT_TIMEOUT);

  logic [ACT_W-1:0] act_cnt_q, act_cnt_d;
  logic             act_q, act_d;

  // Hold-off counter: pinned at the timeout while a transfer runs, so the
  // countdown measures time since the last transfer ended.
  always_comb begin
    if (start_s || busy_q) begin
      act_cnt_d = ACT_RELOAD;
    end else if (ce && (act_cnt_q != '0)) begin
      act_cnt_d = act_cnt_q - ACT_W'(1);
    end else begin
      act_cnt_d = act_cnt_q;
    end
    act_d = (act_cnt_d != '0) || busy_d;
  end

  // Activity counter and indicator registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      act_cnt_q <= '0;
      act_q     <= 1'b0;
    end else begin
      act_cnt_q <= act_cnt_d;
      act_q     <= act_d;
    end
  end

  assign act = act_q;
`endif

endmodule

// File: tb/tb_zc_spi_host.sv
`timescale 1ns/1ps
module tb_zc_spi_host;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ce1     = 1'b1;
  logic ce3     = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  zc_spi_host_if if1();
  zc_spi_host_if if3();

`ifdef ZC_SPI_ACT_EN
  logic act1, act3;
  zc_spi_host #(.DIV(1), .ACT_TIMEOUT(10)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce1), .bus(if1.master), .act(act1));
  zc_spi_host #(.DIV(3), .ACT_TIMEOUT(10)) dut3 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce3), .bus(if3.master), .act(act3));
`else
  zc_spi_host #(.DIV(1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce1), .bus(if1.master));
  zc_spi_host #(.DIV(3)) dut3 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce3), .bus(if3.master));
`endif

  always #5 clk_sys = ~clk_sys;

  // ce for the DIV=3 instance: one tick every third clk_sys cycle
  int cyc3 = 0;
  initial forever begin
    @(negedge clk_sys);
    ce3  = (cyc3 == 0);
    cyc3 = (cyc3 + 1) % 3;
  end

  // Slave card models: present byte MSB first, advance on falling SD_CLK
  logic [7:0] slv1 = 8'hFF, slv3 = 8'hFF;
  logic [3:0] sidx1 = 4'd8, sidx3 = 4'd8;
  assign if1.SD_MISO = (sidx1 < 4'd8) ? slv1[3'd7 - sidx1[2:0]] : 1'b1;
  assign if3.SD_MISO = (sidx3 < 4'd8) ? slv3[3'd7 - sidx3[2:0]] : 1'b1;
  initial forever begin @(negedge if1.SD_CLK); sidx1 = sidx1 + 4'd1; end
  initial forever begin @(negedge if3.SD_CLK); sidx3 = sidx3 + 4'd1; end

  // Observers for instance 1
  logic       prev_sclk1 = 1'b0;
  logic [7:0] mosi_byte1 = 8'h00;
  logic [7:0] rx_prev1   = 8'hFF;
  int mosi_n1 = 0, busy_cyc1 = 0, done_cnt1 = 0, rx_glitch1 = 0;
  int act_after1 = 0, act_bad1 = 0;
  initial forever begin
    @(negedge clk_sys);
    if (if1.SD_CLK && !prev_sclk1) begin
      mosi_byte1 = {mosi_byte1[6:0], if1.SD_MOSI};
      mosi_n1++;
    end
    prev_sclk1 = if1.SD_CLK;
    if (if1.busy) busy_cyc1++;
    if (if1.done) done_cnt1++;
    if ((if1.rx_data !== rx_prev1) && !if1.done) rx_glitch1++;
    rx_prev1 = if1.rx_data;
`ifdef ZC_SPI_ACT_EN
    if (act1 && !if1.busy) act_after1++;
    if (!act1 && if1.busy) act_bad1++;
`endif
  end

  // Observers for instance 3, including SD_CLK phase lengths in clk_sys cycles
  logic       prev_sclk3 = 1'b0;
  logic [7:0] mosi_byte3 = 8'h00;
  int mosi_n3 = 0, busy_cyc3 = 0, done_cnt3 = 0;
  int hi_run3 = 0, lo_run3 = 0, phase_n3 = 0, phase_bad3 = 0;
  initial forever begin
    @(negedge clk_sys);
    if (if3.SD_CLK && !prev_sclk3) begin
      mosi_byte3 = {mosi_byte3[6:0], if3.SD_MOSI};
      mosi_n3++;
      phase_n3++;
      if (lo_run3 != 9) phase_bad3++;
      lo_run3 = 0;
    end
    if (!if3.SD_CLK && prev_sclk3) begin
      phase_n3++;
      if (hi_run3 != 9) phase_bad3++;
      hi_run3 = 0;
    end
    prev_sclk3 = if3.SD_CLK;
    if (if3.SD_CLK) hi_run3++;
    else if (if3.busy) lo_run3++;
    if (if3.busy) busy_cyc3++;
    if (if3.done) done_cnt3++;
  end

  task automatic start1(input bit use_tx, input bit use_rx,
                        input logic [7:0] tx, input logic [7:0] slv);
    @(negedge clk_sys); #1;
    mosi_byte1 = 8'h00; mosi_n1 = 0; busy_cyc1 = 0; done_cnt1 = 0;
    rx_glitch1 = 0; act_after1 = 0; act_bad1 = 0;
    slv1 = slv; sidx1 = 4'd0;
    if1.tx_data = tx; if1.tx_start = use_tx; if1.rx_start = use_rx;
    @(negedge clk_sys); #1;
    if1.tx_start = 1'b0; if1.rx_start = 1'b0;
  endtask

  task automatic wait_done1(input int limit, output bit to);
    int i = 0;
    while (done_cnt1 == 0 && i < limit) begin
      @(negedge clk_sys); #1;
      i++;
    end
    to = (done_cnt1 == 0);
    repeat (3) @(negedge clk_sys);
    #1;
  endtask

  task automatic write_cs1(input logic v);
    @(negedge clk_sys); #1;
    if1.cs_din = v; if1.cs_wr = 1'b1;
    @(negedge clk_sys); #1;
    if1.cs_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    #1;
    n_total++; if (if1.SD_CS_N !== 1'b1) $display("FAIL reset_cs: got %b want 1", if1.SD_CS_N); else n_pass++;
    n_total++; if (if1.SD_CLK !== 1'b0) $display("FAIL reset_sclk: got %b want 0", if1.SD_CLK); else n_pass++;
    n_total++; if (if1.SD_MOSI !== 1'b1) $display("FAIL reset_mosi: got %b want 1", if1.SD_MOSI); else n_pass++;
    n_total++; if (if1.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if1.busy); else n_pass++;
    n_total++; if (if1.done !== 1'b0) $display("FAIL reset_done: got %b want 0", if1.done); else n_pass++;
    n_total++; if (if1.rx_data !== 8'hFF) $display("FAIL reset_rx: got %h want ff", if1.rx_data); else n_pass++;
    n_total++; if (if3.rx_data !== 8'hFF) $display("FAIL reset_rx3: got %h want ff", if3.rx_data); else n_pass++;
`ifdef ZC_SPI_ACT_EN
    n_total++; if (act1 !== 1'b0 || act3 !== 1'b0) $display("FAIL reset_act: got %b%b want 00", act1, act3); else n_pass++;
`endif
  endtask

  task automatic test_tx();
    bit to;
    write_cs1(1'b0);
    n_total++; if (if1.SD_CS_N !== 1'b0) $display("FAIL cs_write: got %b want 0", if1.SD_CS_N); else n_pass++;
    start1(1'b1, 1'b0, 8'hA5, 8'h3C);
    wait_done1(60, to);
    n_total++; if (to) $display("FAIL tx_timeout: got no done want done"); else n_pass++;
    n_total++; if (mosi_byte1 !== 8'hA5 || mosi_n1 != 8) $display("FAIL tx_mosi: got %h/%0d want a5/8", mosi_byte1, mosi_n1); else n_pass++;
    n_total++; if (busy_cyc1 != 16) $display("FAIL tx_busy_len: got %0d want 16", busy_cyc1); else n_pass++;
    n_total++; if (done_cnt1 != 1) $display("FAIL tx_done_cnt: got %0d want 1", done_cnt1); else n_pass++;
    n_total++; if (if1.rx_data !== 8'h3C) $display("FAIL tx_rx: got %h want 3c", if1.rx_data); else n_pass++;
    n_total++; if (if1.SD_MOSI !== 1'b1) $display("FAIL tx_idle_mosi: got %b want 1", if1.SD_MOSI); else n_pass++;
  endtask

  task automatic test_rx();
    bit to;
    start1(1'b0, 1'b1, 8'($urandom), 8'h01);
    wait_done1(60, to);
    n_total++; if (to) $display("FAIL rx_timeout: got no done want done"); else n_pass++;
    n_total++; if (mosi_byte1 !== 8'hFF) $display("FAIL rx_mosi: got %h want ff", mosi_byte1); else n_pass++;
    n_total++; if (if1.rx_data !== 8'h01) $display("FAIL rx_data: got %h want 01", if1.rx_data); else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] tx, slv, exp_mosi;
      bit use_tx;
      tx = 8'($urandom); slv = 8'($urandom); use_tx = 1'($urandom);
      exp_mosi = use_tx ? tx : 8'hFF;
      start1(use_tx, !use_tx, tx, slv);
      wait_done1(60, to);
      n_total++; if (to || done_cnt1 != 1) $display("FAIL rand_done[%0d]: got %0d want 1", k, done_cnt1); else n_pass++;
      n_total++; if (mosi_byte1 !== exp_mosi) $display("FAIL rand_mosi[%0d]: got %h want %h", k, mosi_byte1, exp_mosi); else n_pass++;
      n_total++; if (if1.rx_data !== slv) $display("FAIL rand_rx[%0d]: got %h want %h", k, if1.rx_data, slv); else n_pass++;
      n_total++; if (busy_cyc1 != 16 || rx_glitch1 != 0) $display("FAIL rand_busy[%0d]: got %0d/%0d want 16/0", k, busy_cyc1, rx_glitch1); else n_pass++;
    end
  endtask

  task automatic test_ce_freeze();
    bit to;
    logic [7:0] tx, slv;
    logic s_clk, s_mosi;
    int s_n;
    tx = 8'($urandom); slv = 8'($urandom);
    start1(1'b1, 1'b0, tx, slv);
    repeat (4) @(negedge clk_sys);
    #1;
    s_clk = if1.SD_CLK; s_mosi = if1.SD_MOSI; s_n = mosi_n1;
    ce1 = 1'b0;
    // chip select changes mid-transfer while ce is low
    if1.cs_din = 1'b1; if1.cs_wr = 1'b1;
    @(negedge clk_sys); #1;
    if1.cs_wr = 1'b0;
    n_total++; if (if1.SD_CS_N !== 1'b1) $display("FAIL frz_cs: got %b want 1", if1.SD_CS_N); else n_pass++;
    repeat (9) @(negedge clk_sys);
    #1;
    n_total++; if (if1.SD_CLK !== s_clk || if1.SD_MOSI !== s_mosi || mosi_n1 != s_n) $display("FAIL frz_lines: got %b%b/%0d want %b%b/%0d", if1.SD_CLK, if1.SD_MOSI, mosi_n1, s_clk, s_mosi, s_n); else n_pass++;
    n_total++; if (if1.busy !== 1'b1) $display("FAIL frz_busy: got %b want 1", if1.busy); else n_pass++;
    ce1 = 1'b1;
    wait_done1(80, to);
    n_total++; if (to || done_cnt1 != 1) $display("FAIL frz_done: got %0d want 1", done_cnt1); else n_pass++;
    n_total++; if (busy_cyc1 != 26) $display("FAIL frz_busy_len: got %0d want 26", busy_cyc1); else n_pass++;
    n_total++; if (mosi_byte1 !== tx || if1.rx_data !== slv) $display("FAIL frz_data: got %h/%h want %h/%h", mosi_byte1, if1.rx_data, tx, slv); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    start1(1'b1, 1'b1, 8'h40, 8'h5A);
    repeat (5) @(negedge clk_sys);
    #1;
    if1.tx_data = 8'h0F; if1.tx_start = 1'b1;
    @(negedge clk_sys); #1;
    if1.tx_start = 1'b0;
    wait_done1(60, to);
    repeat (20) @(negedge clk_sys);
    #1;
    n_total++; if (to) $display("FAIL b2b_timeout: got no done want done"); else n_pass++;
    n_total++; if (mosi_byte1 !== 8'h40 || mosi_n1 != 8) $display("FAIL b2b_mosi: got %h/%0d want 40/8", mosi_byte1, mosi_n1); else n_pass++;
    n_total++; if (done_cnt1 != 1) $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt1); else n_pass++;
    n_total++; if (busy_cyc1 != 16 || if1.rx_data !== 8'h5A) $display("FAIL b2b_busy_rx: got %0d/%h want 16/5a", busy_cyc1, if1.rx_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int i = 0;
    write_cs1(1'b0);
    start1(1'b1, 1'b0, 8'hC3, 8'h99);
    while (mosi_n1 < 5 && i < 40) begin
      @(negedge clk_sys); #1;
      i++;
    end
    n_total++; if (mosi_n1 != 5) $display("FAIL rmid_reach: got %0d want 5", mosi_n1); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (if1.SD_CS_N !== 1'b1 || if1.SD_CLK !== 1'b0 || if1.SD_MOSI !== 1'b1) $display("FAIL rmid_lines: got %b%b%b want 101", if1.SD_CS_N, if1.SD_CLK, if1.SD_MOSI); else n_pass++;
    n_total++; if (if1.busy !== 1'b0 || if1.rx_data !== 8'hFF) $display("FAIL rmid_state: got %b/%h want 0/ff", if1.busy, if1.rx_data); else n_pass++;
    repeat (3) @(negedge clk_sys);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk_sys);
    #1;
    n_total++; if (done_cnt1 != 0 || if1.busy !== 1'b0) $display("FAIL rmid_no_done: got %0d/%b want 0/0", done_cnt1, if1.busy); else n_pass++;
  endtask

  task automatic test_div3();
    int i = 0;
    logic [7:0] tx, slv;
    tx = 8'($urandom); slv = 8'($urandom);
    @(negedge clk_sys); #1;
    while (ce3 !== 1'b1) begin @(negedge clk_sys); #1; end
    mosi_byte3 = 8'h00; mosi_n3 = 0; busy_cyc3 = 0; done_cnt3 = 0;
    hi_run3 = 0; lo_run3 = 0; phase_n3 = 0; phase_bad3 = 0;
    slv3 = slv; sidx3 = 4'd0;
    if3.tx_data = tx; if3.tx_start = 1'b1;
    @(negedge clk_sys); #1;
    if3.tx_start = 1'b0;
    while (done_cnt3 == 0 && i < 300) begin
      @(negedge clk_sys); #1;
      i++;
    end
    repeat (3) @(negedge clk_sys);
    #1;
    n_total++; if (done_cnt3 != 1) $display("FAIL div3_done: got %0d want 1", done_cnt3); else n_pass++;
    n_total++; if (busy_cyc3 != 144) $display("FAIL div3_len: got %0d want 144", busy_cyc3); else n_pass++;
    n_total++; if (phase_n3 != 16 || phase_bad3 != 0) $display("FAIL div3_phases: got %0d/%0d want 16/0", phase_n3, phase_bad3); else n_pass++;
    n_total++; if (mosi_byte3 !== tx || if3.rx_data !== slv) $display("FAIL div3_data: got %h/%h want %h/%h", mosi_byte3, if3.rx_data, tx, slv); else n_pass++;
  endtask

`ifdef ZC_SPI_ACT_EN
  task automatic test_act();
    bit to;
    start1(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    wait_done1(60, to);
    repeat (20) @(negedge clk_sys);
    #1;
    n_total++; if (act_after1 != 10) $display("FAIL act_hold: got %0d want 10", act_after1); else n_pass++;
    n_total++; if (act_bad1 != 0 || act1 !== 1'b0) $display("FAIL act_level: got %0d/%b want 0/0", act_bad1, act1); else n_pass++;
  endtask
`endif

  initial begin
    if1.tx_start = 1'b0; if1.rx_start = 1'b0; if1.tx_data = 8'h00;
    if1.cs_wr = 1'b0; if1.cs_din = 1'b1;
    if3.tx_start = 1'b0; if3.rx_start = 1'b0; if3.tx_data = 8'h00;
    if3.cs_wr = 1'b0; if3.cs_din = 1'b1;
    test_reset();
    test_tx();
    test_rx();
    test_random();
    test_ce_freeze();
    test_back_to_back();
    test_reset_mid();
    test_div3();
`ifdef ZC_SPI_ACT_EN
    test_act();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
